// File: rtl/parking_gate_ctrl.sv
// Parking barrier controller: serves entry/exit requests one at a time, holds the
// gate open for GATE_CYCLES per admitted car and keeps occupancy within CAPACITY.
module parking_gate_ctrl #(
    parameter int CAPACITY    = 9,
    parameter int CNT_W       = 4,
    parameter int GATE_CYCLES = 50_000_000,
    parameter int TMR_W       = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             entry_p,
    input  logic             exit_p,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             gate_open,
    output logic             gate_dir,
    output logic             reject,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CAP_V   = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [TMR_W-1:0] TMR_LD  = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE = {{(TMR_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             pend_in_q, pend_in_d;
    logic             pend_out_q, pend_out_d;
    logic             reject_q, reject_d;

    logic             full_s, empty_s, req_in_s, req_out_s;

    assign full_s    = (count_q == CAP_V);
    assign empty_s   = (count_q == {CNT_W{1'b0}});
    assign req_in_s  = entry_p | pend_in_q;
    assign req_out_s = exit_p | pend_out_q;

    // Next-state: IDLE arbitration (exit first) and open-gate countdown.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        timer_d    = timer_q;
        pend_in_d  = pend_in_q;
        pend_out_d = pend_out_q;
        reject_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_out_s && !empty_s) begin
                    state_d    = OPEN_OUT;
                    timer_d    = TMR_LD;
                    pend_out_d = 1'b0;
                    pend_in_d  = req_in_s;
                end else if (req_out_s) begin
                    reject_d   = 1'b1;
                    pend_out_d = 1'b0;
                    pend_in_d  = req_in_s;
                end else if (req_in_s && !full_s) begin
                    state_d   = OPEN_IN;
                    timer_d   = TMR_LD;
                    pend_in_d = 1'b0;
                end else if (req_in_s) begin
                    reject_d  = 1'b1;
                    pend_in_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            OPEN_IN, OPEN_OUT: begin
                pend_in_d  = pend_in_q | entry_p;
                pend_out_d = pend_out_q | exit_p;
                if (timer_q == {TMR_W{1'b0}}) begin
                    state_d = IDLE;
                    // Guards keep the counter from wrapping even if parameters are odd.
                    if (state_q == OPEN_IN) begin
                        if (count_q < CAP_V) begin
                            count_d = count_q + CNT_ONE;
                        end else begin
                            count_d = count_q;
                        end
                    end else begin
                        if (!empty_s) begin
                            count_d = count_q - CNT_ONE;
                        end else begin
                            count_d = count_q;
                        end
                    end
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= {CNT_W{1'b0}};
            timer_q    <= {TMR_W{1'b0}};
            pend_in_q  <= 1'b0;
            pend_out_q <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            pend_in_q  <= pend_in_d;
            pend_out_q <= pend_out_d;
            reject_q   <= reject_d;
        end
    end

    assign count     = count_q;
    assign full      = full_s;
    assign empty     = empty_s;
    assign gate_open = (state_q != IDLE);
    assign gate_dir  = (state_q == OPEN_IN);
    assign reject    = reject_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
- Consumes the debounced, one-pulsed push-button events (`entry_p`, `exit_p`) from the button pre-processing stage.
- Runs a gate FSM that opens the barrier for a fixed time per admitted car and tracks lot occupancy up to a capacity limit.
- Queues at most one pending request per direction while the gate is busy.
- Its outputs drive the LED/7-segment display stage.

Parameters:
- CAPACITY, 9: maximum occupancy; must be ≤ 2^CNT_W−1.
- CNT_W, 4: width of the occupancy counter.
- GATE_CYCLES, 50_000_000: clk cycles the gate stays open per admitted car; must be ≥ 1. Benches use 4.
- TMR_W, 26: timer width; must satisfy GATE_CYCLES−1 < 2^TMR_W.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- entry_p  input  1  single-cycle entry request pulse (from button stage, pressed[1]).
- exit_p  input  1  single-cycle exit request pulse (from button stage, pressed[0]).
- count  output  CNT_W  current occupancy, registered.
- full  output  1  count == CAPACITY (decoded from registered count).
- empty  output  1  count == 0.
- gate_open  output  1  gate actuator; high while in OPEN_IN or OPEN_OUT.
- gate_dir  output  1  1 = entry, 0 = exit; valid while gate_open, 0 in IDLE.
- reject  output  1  one-cycle pulse: served request was refused.
- busy  output  1  state != IDLE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: all state cleared on the cycle rst is sampled high, including mid-open.
  - state = IDLE, count = 0, timer = 0, pend_in = 0, pend_out = 0, reject = 0.
  - Hence gate_open = 0, gate_dir = 0, busy = 0, empty = 1, full = 0.
- States:
  - IDLE: gate closed.
  - OPEN_IN: gate open, entry direction.
  - OPEN_OUT: gate open, exit direction.
- Request capture:
  - req_in = entry_p | pend_in; req_out = exit_p | pend_out.
  - In OPEN_*: entry_p sets pend_in and exit_p sets pend_out, one deep. Extra pulses in the same direction merge; no overflow indication.
- IDLE arbitration (one decision per cycle; exit has priority because it frees space):
  - req_out && !empty: go to OPEN_OUT, load timer = GATE_CYCLES−1, clear pend_out. Pending/incoming entry is kept in pend_in.
  - req_out && empty: reject = 1 next cycle, clear pend_out, stay IDLE. Entry request is kept in pend_in and served next cycle.
  - Else req_in && !full: go to OPEN_IN, load timer, clear pend_in.
  - Else req_in && full: reject = 1, clear pend_in, stay IDLE.
  - A new pulse in the same direction as the request being served in that cycle merges with it; no second request.
- OPEN_* behaviour:
  - timer decrements by 1 each cycle.
  - When timer == 0, the next edge does: state → IDLE, and count +1 (OPEN_IN) or −1 (OPEN_OUT).
  - gate_open is high for exactly GATE_CYCLES cycles. count changes on the same edge gate_open falls.
  - A pending request is evaluated in the first IDLE cycle, so the gate reopens after exactly one closed cycle.
- Arithmetic:
  - count never wraps. Increments are admitted only when count < CAPACITY; decrements only when count > 0.
  - Decisions use the registered count at the IDLE decision cycle.
- reject is registered: high exactly one cycle, the cycle after the refusing decision.

Test Plan:
- Reset (CAPACITY=3, GATE_CYCLES=4): hold rst 2 cycles → count=0, empty=1, full=0, gate_open=0, reject=0.
- Single entry: entry_p pulse at cycle t →
  - gate_open=1 and gate_dir=1 on cycles t+1..t+4;
  - count=1 and gate_open=0 at t+5;
  - empty=0.
- Fill to capacity, then overflow: 3 spaced entries → count=3, full=1. 4th entry_p → reject high one cycle, no gate_open, count stays 3. exit_p on empty lot → reject, count stays 0.
- Simultaneous pulses with count=1, both pulses at cycle t:
  - OPEN_OUT first, count=0;
  - one closed IDLE cycle;
  - then OPEN_IN, final count=1;
  - reject never asserts.
- Pulses while busy: during OPEN_IN send 3 entry_p pulses and 1 exit_p → exactly one OPEN_OUT then one OPEN_IN follow; extra entries merge; net count +1 overall.
- Reset mid-operation: assert rst at 2nd open cycle with pend_in set → next cycle gate_open=0, count=0, pending cleared; no further gate activity.
